// File: rtl/serial_chunk_addsub.sv
// Multi-cycle signed adder/subtractor that walks the operands CHUNK bits per
// cycle (LSB chunk first), with optional saturation and a sticky overflow flag.
module serial_chunk_addsub #(
    parameter int WIDTH    = 16,
    parameter int CHUNK    = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             carry_out,
    output logic             sticky_ovf,
    input  logic             clr_sticky
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    generate
        if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("serial_chunk_addsub: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic signed [WIDTH-1:0] a_q;
    logic signed [WIDTH-1:0] b_q;     // already inverted for subtraction
    logic signed [WIDTH-1:0] res_q;
    logic              carry_q;
    logic [CW-1:0]     cnt_q;
    logic              ovf_q;
    logic              cout_q;
    logic              out_valid_q;
    logic              sticky_q;

    logic [CHUNK:0]    chunk_sum;
    logic [WIDTH-1:0]  res_wrap;
    logic              last_chunk;
    logic              msb_cin;
    logic              msb_cout;
    logic              ovf_calc;
    int                base;

    // Clamp toward the sign of a on overflow; wrap otherwise or when saturation is off.
    function automatic logic [WIDTH-1:0] sat_result(input logic [WIDTH-1:0] wrap,
                                                    input logic             ovf,
                                                    input logic             a_sign);
        logic [WIDTH-1:0] r;
        r = wrap;
        if (SATURATE && ovf) begin
            r = a_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
        return r;
    endfunction

    // One chunk of ripple addition plus the MSB carry analysis used on the last chunk.
    always_comb begin
        base       = int'(cnt_q) * CHUNK;
        chunk_sum  = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
                   + {{CHUNK{1'b0}}, carry_q};
        res_wrap   = res_q;
        res_wrap[base +: CHUNK] = chunk_sum[CHUNK-1:0];
        last_chunk = (cnt_q == CW'(NCH - 1));
        msb_cout   = chunk_sum[CHUNK];
        // Carry into the MSB recovered from the MSB's own sum bit: s = a ^ b ^ cin.
        msb_cin    = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ res_wrap[WIDTH-1];
        ovf_calc   = msb_cin ^ msb_cout;
    end

    // Next-state logic for IDLE -> CALC -> DONE -> IDLE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (in_valid)   state_next = ST_CALC;
            ST_CALC: if (last_chunk) state_next = ST_DONE;
            ST_DONE: if (out_ready)  state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    // State register and registered out_valid decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_next;
            out_valid_q <= (state_next == ST_DONE);
        end
    end

    // Operand capture and chunk-serial accumulation into the result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b ^ {WIDTH{sub}};
                        carry_q <= sub;
                        cnt_q   <= '0;
                    end
                end
                ST_CALC: begin
                    carry_q <= chunk_sum[CHUNK];
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_chunk) begin
                        res_q  <= sat_result(res_wrap, ovf_calc, a_q[WIDTH-1]);
                        ovf_q  <= ovf_calc;
                        cout_q <= msb_cout;
                    end else begin
                        res_q  <= res_wrap;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Sticky overflow: a delivered overflow sets it and takes priority over a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else if (out_valid_q && out_ready && ovf_q) begin
            sticky_q <= 1'b1;
        end else if (clr_sticky) begin
            sticky_q <= 1'b0;
        end
    end

    assign in_ready   = (state == ST_IDLE);
    assign out_valid  = out_valid_q;
    assign result     = res_q;
    assign overflow   = ovf_q;
    assign carry_out  = cout_q;
    assign sticky_ovf = sticky_q;

endmodule

// File: tb/tb_serial_chunk_addsub.sv
// Bench for serial_chunk_addsub: four instances (CHUNK 4/4/1/16, wrap and saturate)
// driven in lockstep, directed cases followed by random ops against an arithmetic model.
module tb_serial_chunk_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        out_ready;
    logic        clr_sticky;

    logic [3:0]        in_ready_o;
    logic [3:0]        out_valid_o;
    logic [3:0]        ovf_o;
    logic [3:0]        cout_o;
    logic [3:0]        sticky_o;
    logic [3:0][15:0]  res_o;

    // Instances 1 and 3 saturate.
    localparam logic [3:0] SAT_MASK = 4'b1010;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_chunk_addsub #(.WIDTH(16), .CHUNK(4), .SATURATE(1'b0)) u_c4_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_o[0]),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid_o[0]), .out_ready(out_ready),
        .result(res_o[0]), .overflow(ovf_o[0]), .carry_out(cout_o[0]),
        .sticky_ovf(sticky_o[0]), .clr_sticky(clr_sticky));

    serial_chunk_addsub #(.WIDTH(16), .CHUNK(4), .SATURATE(1'b1)) u_c4_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_o[1]),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid_o[1]), .out_ready(out_ready),
        .result(res_o[1]), .overflow(ovf_o[1]), .carry_out(cout_o[1]),
        .sticky_ovf(sticky_o[1]), .clr_sticky(clr_sticky));

    serial_chunk_addsub #(.WIDTH(16), .CHUNK(1), .SATURATE(1'b0)) u_c1_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_o[2]),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid_o[2]), .out_ready(out_ready),
        .result(res_o[2]), .overflow(ovf_o[2]), .carry_out(cout_o[2]),
        .sticky_ovf(sticky_o[2]), .clr_sticky(clr_sticky));

    serial_chunk_addsub #(.WIDTH(16), .CHUNK(16), .SATURATE(1'b1)) u_c16_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_o[3]),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid_o[3]), .out_ready(out_ready),
        .result(res_o[3]), .overflow(ovf_o[3]), .carry_out(cout_o[3]),
        .sticky_ovf(sticky_o[3]), .clr_sticky(clr_sticky));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: true signed arithmetic in 32 bits, then wrap or clamp.
    function automatic void model(input logic [15:0] ma, input logic [15:0] mb,
                                  input logic msub, input logic msat,
                                  output logic [15:0] r, output logic o, output logic c);
        int ia;
        int ib;
        int v;
        ia = $signed(ma);
        ib = $signed(mb);
        v  = msub ? ia - ib : ia + ib;
        o  = (v > 32767) || (v < -32768);
        c  = msub ? (ma >= mb) : ((32'(ma) + 32'(mb)) > 32'd65535);
        r  = (msat && o) ? (ma[15] ? 16'h8000 : 16'h7FFF) : v[15:0];
    endfunction

    // Present one operation for a single cycle (all instances are in IDLE).
    task automatic start_op(input logic [15:0] ta, input logic [15:0] tb, input logic ts);
        a        = ta;
        b        = tb;
        sub      = ts;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) until every instance shows out_valid; report latency of instance 0.
    task automatic wait_done(output int lat0);
        int cyc;
        cyc  = 0;
        lat0 = 0;
        while (out_valid_o != 4'hF && cyc < 64) begin
            @(posedge clk);
            #1;
            cyc++;
            if (out_valid_o[0] && lat0 == 0) lat0 = cyc;
        end
        chk("all_done", out_valid_o, 4'hF);
    endtask

    task automatic deliver();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // Full operation checked on all instances against the model.
    task automatic run_check(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                             input logic ts);
        int          lat;
        logic [15:0] er;
        logic        eo;
        logic        ec;
        start_op(ta, tb, ts);
        wait_done(lat);
        for (int d = 0; d < 4; d++) begin
            model(ta, tb, ts, SAT_MASK[d], er, eo, ec);
            chk($sformatf("%s_res%0d", tag, d),  res_o[d],  er);
            chk($sformatf("%s_ovf%0d", tag, d),  ovf_o[d],  eo);
            chk($sformatf("%s_cout%0d", tag, d), cout_o[d], ec);
        end
        deliver();
    endtask

    initial begin
        int          lat;
        logic [15:0] held;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rs;

        rst        = 1'b1;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        sub        = 1'b0;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid_o, 4'h0);
        chk("rst_in_ready",  in_ready_o,  4'hF);
        chk("rst_result",    res_o[0],    16'h0000);
        chk("rst_ovf",       ovf_o,       4'h0);
        chk("rst_cout",      cout_o,      4'h0);
        chk("rst_sticky",    sticky_o,    4'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: plain add with latency check
        start_op(16'h1234, 16'h0F0F, 1'b0);
        chk("t1_in_ready_busy", in_ready_o[0], 1'b0);
        wait_done(lat);
        chk("t1_latency", lat, 4);
        chk("t1_result", res_o[0], 16'h2143);
        chk("t1_ovf", ovf_o[0], 1'b0);
        chk("t1_cout", cout_o[0], 1'b0);
        chk("t1_result_c1", res_o[2], 16'h2143);
        deliver();
        chk("t1_back_idle", in_ready_o, 4'hF);
        chk("t1_valid_low", out_valid_o, 4'h0);

        // 2: overflow, wrap vs saturate
        start_op(16'h7FFF, 16'hFFFF, 1'b1);
        wait_done(lat);
        chk("t2_wrap_res", res_o[0], 16'h8000);
        chk("t2_wrap_ovf", ovf_o[0], 1'b1);
        chk("t2_sat_res",  res_o[1], 16'h7FFF);
        chk("t2_sat_ovf",  ovf_o[1], 1'b1);
        chk("t2_sat16_res", res_o[3], 16'h7FFF);
        deliver();
        start_op(16'h8000, 16'h0001, 1'b1);
        wait_done(lat);
        chk("t2_neg_sat_res", res_o[1], 16'h8000);
        chk("t2_neg_sat_ovf", ovf_o[1], 1'b1);
        chk("t2_neg_wrap_res", res_o[0], 16'h7FFF);
        deliver();

        // 3: subtraction borrow behaviour
        start_op(16'h0005, 16'h0005, 1'b1);
        wait_done(lat);
        chk("t3_eq_res",  res_o[0], 16'h0000);
        chk("t3_eq_cout", cout_o[0], 1'b1);
        chk("t3_eq_ovf",  ovf_o[0], 1'b0);
        deliver();
        start_op(16'h0003, 16'h0005, 1'b1);
        wait_done(lat);
        chk("t3_lt_res",  res_o[0], 16'hFFFE);
        chk("t3_lt_cout", cout_o[0], 1'b0);
        chk("t3_lt_ovf",  ovf_o[0], 1'b0);
        chk("t3_lt_res_c1", res_o[2], 16'hFFFE);
        deliver();

        // 4: backpressure in DONE with an ignored in_valid pulse
        start_op(16'h4000, 16'h0123, 1'b0);
        wait_done(lat);
        held = res_o[0];
        chk("t4_first_res", held, 16'h4123);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                a        = 16'h1111;
                b        = 16'h2222;
                in_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk("t4_hold_res",   res_o[0],       16'h4123);
            chk("t4_hold_ready", in_ready_o[0],  1'b0);
            chk("t4_hold_valid", out_valid_o[0], 1'b1);
        end
        deliver();
        repeat (3) @(posedge clk);
        #1;
        chk("t4_no_queued_op", out_valid_o, 4'h0);
        chk("t4_idle", in_ready_o, 4'hF);
        run_check("t4_next", 16'h0042, 16'hFFF0, 1'b0);

        // 5: sticky overflow behaviour
        clr_sticky = 1'b1;
        @(posedge clk);
        #1;
        clr_sticky = 1'b0;
        chk("t5_cleared", sticky_o[0], 1'b0);
        start_op(16'h7FFF, 16'h0001, 1'b0);
        wait_done(lat);
        chk("t5_not_yet", sticky_o[0], 1'b0);
        deliver();
        chk("t5_set", sticky_o[0], 1'b1);
        run_check("t5_clean", 16'h0001, 16'h0001, 1'b0);
        chk("t5_stays", sticky_o[0], 1'b1);
        clr_sticky = 1'b1;
        @(posedge clk);
        #1;
        clr_sticky = 1'b0;
        chk("t5_clr_alone", sticky_o[0], 1'b0);
        start_op(16'h8000, 16'h8000, 1'b0);
        wait_done(lat);
        clr_sticky = 1'b1;
        deliver();
        clr_sticky = 1'b0;
        chk("t5_set_wins", sticky_o[0], 1'b1);
        clr_sticky = 1'b1;
        @(posedge clk);
        #1;
        clr_sticky = 1'b0;
        chk("t5_clr_again", sticky_o[0], 1'b0);

        // 6: reset during the second CALC cycle
        start_op(16'h1234, 16'h1111, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t6_valid_low", out_valid_o, 4'h0);
        chk("t6_idle",      in_ready_o,  4'hF);
        chk("t6_result_clr", res_o[0],   16'h0000);
        run_check("t6_after", 16'h1234, 16'h1111, 1'b0);

        // Random operations across all instances
        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            run_check("rnd", ra, rb, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
